// File: rtl/xgmac_rx_frame_filter.sv
// Store-and-forward RX frame filter: buffers MAC frames and forwards only those that end cleanly.
// Frames flagged bad on tlast, or that overflow the buffer, are rolled back and never leave.
module xgmac_rx_frame_filter #(
    parameter int unsigned ADDR_WIDTH = 9
) (
    input  logic        rx_clk,
    input  logic        rx_axis_aresetn,
    input  logic [63:0] s_axis_tdata,
    input  logic [7:0]  s_axis_tkeep,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    input  logic        s_axis_tvalid,
    output logic [63:0] m_axis_tdata,
    output logic [7:0]  m_axis_tkeep,
    output logic        m_axis_tlast,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] good_frames,
    output logic [31:0] bad_frames,
    output logic [31:0] ovf_frames
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic {ST_ACCEPT, ST_DROP} wr_state_t;

    wr_state_t         r_state;
    logic [72:0]       r_mem [DEPTH];
    logic [ADDR_WIDTH:0] r_wr_ptr;
    logic [ADDR_WIDTH:0] r_wr_commit;
    logic [ADDR_WIDTH:0] r_rd_ptr;
    logic [31:0]       r_good;
    logic [31:0]       r_bad;
    logic [31:0]       r_ovf;
    logic [72:0]       r_ram_q;
    logic              r_ram_v;
    logic [63:0]       r_out_data;
    logic [7:0]        r_out_keep;
    logic              r_out_last;
    logic              r_out_v;

    logic [ADDR_WIDTH:0] w_fill;
    logic [ADDR_WIDTH:0] w_wr_ptr_nxt;
    logic              w_full;
    logic              w_avail;
    logic              w_wr_en;
    logic              w_out_free;
    logic              w_load;
    logic              w_rd_en;

    assign w_fill       = r_wr_ptr - r_rd_ptr;
    assign w_wr_ptr_nxt = r_wr_ptr + PTR_ONE;
    assign w_full       = (w_fill == FULL_LVL);
    assign w_avail      = (r_rd_ptr != r_wr_commit);
    assign w_wr_en      = (r_state == ST_ACCEPT) && s_axis_tvalid && !w_full;

    // RAM stage refills whenever it is empty or its word moves to the output this cycle.
    assign w_out_free   = !r_out_v || m_axis_tready;
    assign w_load       = r_ram_v && w_out_free;
    assign w_rd_en      = w_avail && (!r_ram_v || w_load);

    always_ff @(posedge rx_clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
        if (w_rd_en) begin
            r_ram_q <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge rx_clk or negedge rx_axis_aresetn) begin
        if (!rx_axis_aresetn) begin
            r_state     <= ST_ACCEPT;
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_good      <= '0;
            r_bad       <= '0;
            r_ovf       <= '0;
        end else begin
            case (r_state)
                ST_ACCEPT: begin
                    if (s_axis_tvalid) begin
                        if (!w_full) begin
                            if (s_axis_tlast && s_axis_tuser) begin
                                r_wr_ptr <= r_wr_commit;
                                r_bad    <= r_bad + 32'd1;
                            end else begin
                                r_wr_ptr <= w_wr_ptr_nxt;
                                if (s_axis_tlast) begin
                                    r_wr_commit <= w_wr_ptr_nxt;
                                    r_good      <= r_good + 32'd1;
                                end
                            end
                        end else begin
                            // Overflow: discard the partial frame; a full tlast beat ends it here.
                            r_wr_ptr <= r_wr_commit;
                            r_ovf    <= r_ovf + 32'd1;
                            if (!s_axis_tlast) begin
                                r_state <= ST_DROP;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (s_axis_tvalid && s_axis_tlast) begin
                        r_state <= ST_ACCEPT;
                    end
                end
                default: r_state <= ST_ACCEPT;
            endcase
        end
    end

    always_ff @(posedge rx_clk or negedge rx_axis_aresetn) begin
        if (!rx_axis_aresetn) begin
            r_rd_ptr   <= '0;
            r_ram_v    <= 1'b0;
            r_out_data <= '0;
            r_out_keep <= '0;
            r_out_last <= 1'b0;
            r_out_v    <= 1'b0;
        end else begin
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_rd_en) begin
                r_ram_v <= 1'b1;
            end else if (w_load) begin
                r_ram_v <= 1'b0;
            end
            if (w_load) begin
                r_out_last <= r_ram_q[72];
                r_out_keep <= r_ram_q[71:64];
                r_out_data <= r_ram_q[63:0];
                r_out_v    <= 1'b1;
            end else if (m_axis_tready) begin
                r_out_v <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = r_out_data;
    assign m_axis_tkeep  = r_out_keep;
    assign m_axis_tlast  = r_out_last;
    assign m_axis_tvalid = r_out_v;
    assign good_frames   = r_good;
    assign bad_frames    = r_bad;
    assign ovf_frames    = r_ovf;

endmodule

// File: doc/xgmac_rx_frame_filter.md
# xgmac_rx_frame_filter

Store-and-forward receive frame filter between the 10G MAC receive AXI-Stream (`rx_axis_*` out of the MAC/PHY core) and the address-swap loopback stage. Buffers each incoming frame and releases it downstream only once it has ended cleanly. Frames flagged bad by the MAC (`tuser` high on the `tlast` beat) are discarded whole, as are frames that overflow the buffer. The MAC has no `tready`, so this block absorbs the rate mismatch and gives the downstream stage real backpressure.

## Interface
Parameters:
- `ADDR_WIDTH`, default 9: buffer depth is 2^ADDR_WIDTH words of 73 bits ({tlast, tkeep[7:0], tdata[63:0]}).

Ports (one clock, `rx_clk`; reset `rx_axis_aresetn` is asynchronous, active-low):
- `rx_clk` in 1: 156.25 MHz core clock; all logic is on its rising edge.
- `rx_axis_aresetn` in 1: asynchronous active-low reset; deassertion is synchronous to `rx_clk` externally.
- `s_axis_tdata` in 64: MAC receive data.
- `s_axis_tkeep` in 8: byte enables; contiguous from bit 0.
- `s_axis_tlast` in 1: last beat of frame.
- `s_axis_tuser` in 1: bad-frame flag; sampled only on the `tlast` beat.
- `s_axis_tvalid` in 1: beat valid; no ready, so every valid beat is consumed.
- `m_axis_tdata` out 64: to address swap.
- `m_axis_tkeep` out 8
- `m_axis_tlast` out 1
- `m_axis_tvalid` out 1
- `m_axis_tready` in 1: downstream ready.
- `good_frames` out 32: count of committed frames; wraps.
- `bad_frames` out 32: count of frames dropped for `tuser`; wraps.
- `ovf_frames` out 32: count of frames dropped for overflow; wraps.

## Operation
- Pointers `wr_ptr` (speculative), `wr_commit`, and `rd_ptr` are each ADDR_WIDTH+1 bits.
  - full: `wr_ptr - rd_ptr == 2^ADDR_WIDTH`.
  - data available: `rd_ptr != wr_commit`.
- Write FSM states are ACCEPT and DROP; reset state is ACCEPT.
- ACCEPT, valid beat, not full:
  - Write the word at `wr_ptr[ADDR_WIDTH-1:0]` and increment `wr_ptr`.
  - If `tlast` and `!tuser`: set `wr_commit` to the new `wr_ptr` and increment `good_frames`.
  - If `tlast` and `tuser`: set `wr_ptr` to `wr_commit` (rollback) and increment `bad_frames`.
- ACCEPT, valid beat, full:
  - No write. Set `wr_ptr` to `wr_commit` and increment `ovf_frames`.
  - If `!tlast`, go to DROP. A full-on-`tlast` beat stays in ACCEPT.
- DROP: discard all beats. On a valid `tlast` beat, go to ACCEPT. No counter changes.
- `tuser` on a non-`tlast` beat is ignored.
- Read side:
  - Synchronous RAM read followed by a one-word output register.
  - Prefetch keeps a one-word skid so throughput is 1 word/cycle while `m_axis_tready=1`.
  - `rd_ptr` advances per word moved into the output pipeline.
- Downstream only ever sees whole, good frames, in arrival order, with bit-exact tdata, tkeep and tlast.
- Simultaneous write-commit and read in the same cycle are legal. Full and available are computed from the register values before the edge.
- Pointer wrap is natural modulo 2^(ADDR_WIDTH+1).

## Timing
- Reset values: `m_axis_tvalid=0`, `m_axis_tdata=0`, `m_axis_tkeep=0`, `m_axis_tlast=0`, all counters 0, all pointers 0, FSM in ACCEPT.
- Reset asserted mid-frame: the partial frame and all buffered frames are lost and `m_axis_tvalid` falls immediately (asynchronous). After release, the first beat seen is treated as a frame start.
- Latency with the output empty: `m_axis_tvalid` rises exactly 2 rising edges after the edge that samples the good `tlast` beat. That edge updates `wr_commit`; the next edge issues the read; the edge after that loads the output.
- AXI-Stream rules on `m_axis`:
  - While `m_axis_tvalid=1` and `m_axis_tready=0`, data, keep and last are held stable.
  - `m_axis_tvalid` never drops without a handshake.
- Counters update on the same edge that samples the deciding beat.

## Test plan
- Good frame: 4 beats of data 0x1..0x4, last `tkeep=8'h0F`, `tuser=0`, `m_axis_tready=1`.
  - m_axis emits the same 4 words; `tvalid` rises 2 cycles after the `tlast` edge.
  - `good_frames=1`.
- Bad frame: 3 beats with `tuser=1` on `tlast`, then a good 2-beat frame.
  - Only the 2-beat frame appears on m_axis.
  - `bad_frames=1`, `good_frames=1`.
- Overflow with `ADDR_WIDTH=4` and `m_axis_tready=0`:
  - Stimulus: a 10-beat good frame, then a 20-beat frame, then a 3-beat frame.
  - `ovf_frames=1`, `good_frames=2`.
  - After raising `tready`, exactly the 10-beat and 3-beat frames emerge.
- Backpressure: 8-beat frame with `m_axis_tready` toggling 1010…
  - All 8 words delivered in order and held stable while `tready=0`.
  - No duplicates or gaps.
- Reset mid-frame: assert `rx_axis_aresetn=0` during beat 3 of 6, release, then send a good 2-beat frame.
  - Outputs are 0 during reset.
  - Only the 2-beat frame is emitted; `good_frames=1`.
- Back-to-back: 50 random-length (1–32 beat) frames with about 20% `tuser=1` and random `tready`.
  - The scoreboard matches all good frames.
  - `good_frames + bad_frames = 50`.
